// File: rtl/vuvmu_ctrl_vec_load_roq_pkg.sv
// Shared sizing constants for the vector load path.
// The issue stage and the reorder queue agree on tag and line widths through this package.
package vuvmu_ctrl_vec_load_roq_pkg;

    // Tag width handed out per load-request-queue enqueue (entry count = 2^tag width).
    localparam int VM_ROQ_TAG_SZ   = 8;
    // Memory response cache-line width in bits.
    localparam int VM_LINE_SZ      = 128;
    // Load request queue entry: line address plus tag.
    localparam int VM_LINE_ADDR_SZ = 28;
    localparam int VM_LRQ_SZ       = VM_LINE_ADDR_SZ + VM_ROQ_TAG_SZ;

endpackage

// File: rtl/vuvmu_roq_data_ram.sv
// Line storage for the reorder queue.
// One synchronous write port (fills) and one combinational read port (head line).
// Contents are not reset; the controller's filled bits decide what is meaningful.
module vuvmu_roq_data_ram
    import vuvmu_ctrl_vec_load_roq_pkg::*;
#(
    parameter int TAG_SZ  = VM_ROQ_TAG_SZ,
    parameter int DATA_SZ = VM_LINE_SZ
) (
    input  logic               clk,
    input  logic               wr_en_i,
    input  logic [TAG_SZ-1:0]  wr_addr_i,
    input  logic [DATA_SZ-1:0] wr_data_i,
    input  logic [TAG_SZ-1:0]  rd_addr_i,
    output logic [DATA_SZ-1:0] rd_data_o
);

    localparam int N = 1 << TAG_SZ;

    logic [DATA_SZ-1:0] mem_q [N];

    // Capture an accepted response line into its tag's slot.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/vuvmu_ctrl_vec_load_roq.sv
// In-order tag allocator and reorder queue for vector-load cache-line responses.
// Tags are handed out at the tail, lines arrive by tag in any order, and lines leave
// strictly from the head in allocation order.
//
// Handshakes: a transfer happens on a cycle where both val and rdy are high at the
// rising edge. val never depends on rdy in this block; rdy while val is low is not a
// transfer. Memory responses have no rdy and are always sampled when memresp_val is high.
module vuvmu_ctrl_vec_load_roq
    import vuvmu_ctrl_vec_load_roq_pkg::*;
#(
    parameter int TAG_SZ  = VM_ROQ_TAG_SZ,
    parameter int DATA_SZ = VM_LINE_SZ
) (
    input  logic               clk,
    input  logic               reset,
    output logic [TAG_SZ-1:0]  roq_deq_tag_bits,
    output logic               roq_deq_tag_val,
    input  logic               roq_deq_tag_rdy,
    input  logic               memresp_val,
    input  logic [TAG_SZ-1:0]  memresp_tag,
    input  logic [DATA_SZ-1:0] memresp_data,
    output logic [DATA_SZ-1:0] ldq_enq_bits,
    output logic               ldq_enq_val,
    input  logic               ldq_enq_rdy,
    output logic [TAG_SZ:0]    roq_cnt,
    output logic               roq_empty,
    output logic               err_spurious_resp
);

    localparam int              N        = 1 << TAG_SZ;
    localparam logic [TAG_SZ:0] CNT_FULL = (TAG_SZ+1)'(N);

    logic [TAG_SZ-1:0] head_q, head_d;
    logic [TAG_SZ-1:0] tail_q, tail_d;
    logic [TAG_SZ:0]   cnt_q, cnt_d;
    logic [N-1:0]      vld_q, vld_d;
    logic              err_q, err_d;

    logic              alloc_fire;
    logic              retire_fire;
    logic [TAG_SZ:0]   resp_offset;
    logic              resp_in_window;
    logic              fill_en;

    // A tag is live when its distance from head (mod N) falls inside the allocated count.
    // A tag being allocated this same cycle is not yet inside the window, so a response
    // racing its own allocation is treated as spurious.
    assign resp_offset    = {1'b0, memresp_tag - head_q};
    assign resp_in_window = resp_offset < cnt_q;
    assign fill_en        = memresp_val & resp_in_window & ~vld_q[memresp_tag];

    assign roq_deq_tag_val  = (cnt_q != CNT_FULL);
    assign roq_deq_tag_bits = tail_q;
    assign ldq_enq_val      = vld_q[head_q] & (cnt_q != '0);
    assign alloc_fire       = roq_deq_tag_val & roq_deq_tag_rdy;
    assign retire_fire      = ldq_enq_val & ldq_enq_rdy;

    assign roq_cnt           = cnt_q;
    assign roq_empty         = (cnt_q == '0);
    assign err_spurious_resp = err_q;

    // Next-state for pointers, occupancy, filled bits and the spurious-response flag.
    // Fill and retire never hit the same entry: retire needs the head already filled,
    // while fill needs its target still empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        err_d  = memresp_val & ~fill_en;

        if (alloc_fire) begin
            tail_d = tail_q + TAG_SZ'(1);
        end

        if (retire_fire) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + TAG_SZ'(1);
        end

        if (fill_en) begin
            vld_d[memresp_tag] = 1'b1;
        end

        case ({alloc_fire, retire_fire})
            2'b10:   cnt_d = cnt_q + (TAG_SZ+1)'(1);
            2'b01:   cnt_d = cnt_q - (TAG_SZ+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Controller state register; reset drops every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    vuvmu_roq_data_ram #(
        .TAG_SZ  (TAG_SZ),
        .DATA_SZ (DATA_SZ)
    ) u_data_ram (
        .clk       (clk),
        .wr_en_i   (fill_en),
        .wr_addr_i (memresp_tag),
        .wr_data_i (memresp_data),
        .rd_addr_i (head_q),
        .rd_data_o (ldq_enq_bits)
    );

endmodule

// File: tb/tb_vuvmu_ctrl_vec_load_roq.sv
// Bench for the vector-load reorder queue, built with a 4-entry queue so full and
// wrap-around are reached quickly. A behavioural model (ordered list of live tags plus
// per-tag filled/data arrays) predicts every output each cycle.
module tb_vuvmu_ctrl_vec_load_roq;

    localparam int TS = 2;
    localparam int DW = 128;
    localparam int N  = 1 << TS;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [TS-1:0] roq_deq_tag_bits;
    logic          roq_deq_tag_val;
    logic          roq_deq_tag_rdy;
    logic          memresp_val;
    logic [TS-1:0] memresp_tag;
    logic [DW-1:0] memresp_data;
    logic [DW-1:0] ldq_enq_bits;
    logic          ldq_enq_val;
    logic          ldq_enq_rdy;
    logic [TS:0]   roq_cnt;
    logic          roq_empty;
    logic          err_spurious_resp;

    always #5 clk = ~clk;

    vuvmu_ctrl_vec_load_roq #(
        .TAG_SZ  (TS),
        .DATA_SZ (DW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .roq_deq_tag_bits  (roq_deq_tag_bits),
        .roq_deq_tag_val   (roq_deq_tag_val),
        .roq_deq_tag_rdy   (roq_deq_tag_rdy),
        .memresp_val       (memresp_val),
        .memresp_tag       (memresp_tag),
        .memresp_data      (memresp_data),
        .ldq_enq_bits      (ldq_enq_bits),
        .ldq_enq_val       (ldq_enq_val),
        .ldq_enq_rdy       (ldq_enq_rdy),
        .roq_cnt           (roq_cnt),
        .roq_empty         (roq_empty),
        .err_spurious_resp (err_spurious_resp)
    );

    // ---------------- reference model and scoreboard ----------------
    int            total = 0;
    int            bad   = 0;
    int            live_q[$];      // allocated tags, oldest first
    bit            filled_m[N];
    logic [DW-1:0] line_m[N];
    int            next_tag;
    bit            err_m;
    logic [DW-1:0] exp_q[$];       // lines expected to leave, in order

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_live(input int t);
        foreach (live_q[i]) begin
            if (live_q[i] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        live_q.delete();
        foreach (filled_m[i]) filled_m[i] = 1'b0;
        next_tag = 0;
        err_m    = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        roq_deq_tag_rdy = 1'b0;
        ldq_enq_rdy     = 1'b0;
        memresp_val     = 1'b0;
        memresp_tag     = '0;
        memresp_data    = '0;
        @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
    endtask

    // One clock: drive inputs, compare every output with the model, then advance the model.
    task automatic step(input bit t_rdy, input bit l_rdy, input bit rv, input int rtag,
                        input logic [DW-1:0] rdata);
        bit exp_val;
        bit do_alloc;
        bit do_retire;
        bit do_fill;
        int t;
        @(negedge clk);
        roq_deq_tag_rdy = t_rdy;
        ldq_enq_rdy     = l_rdy;
        memresp_val     = rv;
        memresp_tag     = rtag[TS-1:0];
        memresp_data    = rdata;
        t               = rtag % N;
        #1;
        exp_val = (live_q.size() > 0) && filled_m[live_q[0]];
        check_eq("tag_val",  roq_deq_tag_val, live_q.size() < N);
        check_eq("tag_bits", roq_deq_tag_bits, next_tag);
        check_eq("ldq_val",  ldq_enq_val, exp_val);
        if (exp_val) check_eq("ldq_bits", ldq_enq_bits, line_m[live_q[0]]);
        check_eq("cnt",      roq_cnt, live_q.size());
        check_eq("empty",    roq_empty, live_q.size() == 0);
        check_eq("err",      err_spurious_resp, err_m);
        if (ldq_enq_val && l_rdy && exp_q.size() > 0) begin
            check_eq("sb_line", ldq_enq_bits, exp_q.pop_front());
        end

        do_alloc  = t_rdy && (live_q.size() < N);
        do_retire = l_rdy && exp_val;
        do_fill   = rv && is_live(t) && !filled_m[t];
        @(posedge clk);
        if (do_retire) begin
            filled_m[live_q[0]] = 1'b0;
            void'(live_q.pop_front());
        end
        if (do_fill) begin
            filled_m[t] = 1'b1;
            line_m[t]   = rdata;
        end
        if (do_alloc) begin
            live_q.push_back(next_tag);
            next_tag = (next_tag + 1) % N;
        end
        err_m = rv && !do_fill;
    endtask

    task automatic idle(input int n, input bit l_rdy);
        for (int i = 0; i < n; i++) step(1'b0, l_rdy, 1'b0, 0, '0);
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    logic [DW-1:0] d0, d1, d2;

    initial begin
        reset           = 1'b1;
        roq_deq_tag_rdy = 1'b0;
        ldq_enq_rdy     = 1'b0;
        memresp_val     = 1'b0;
        memresp_tag     = '0;
        memresp_data    = '0;
        model_reset();

        // Reset then idle.
        do_reset();
        idle(2, 1'b1);

        // Fill the queue, then free the oldest entry and watch the tail wrap.
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b0, 0, '0);
        step(1'b1, 1'b0, 1'b0, 0, '0);   // rdy while full is not a fire
        step(1'b0, 1'b0, 1'b1, 0, {32{4'hA}});
        step(1'b0, 1'b1, 1'b0, 0, '0);
        idle(1, 1'b0);

        // Out-of-order fill, in-order release.
        do_reset();
        d0 = rand_line(); d1 = rand_line(); d2 = rand_line();
        exp_q.push_back(d0); exp_q.push_back(d1); exp_q.push_back(d2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, '0);
        step(1'b0, 1'b1, 1'b1, 2, d2);
        step(1'b0, 1'b1, 1'b1, 1, d1);
        step(1'b0, 1'b1, 1'b1, 0, d0);
        idle(5, 1'b1);

        // Spurious responses: unallocated tag, then already-filled tag.
        do_reset();
        d0 = rand_line(); d1 = rand_line(); d2 = rand_line();
        exp_q.push_back(d0); exp_q.push_back(d1); exp_q.push_back(d2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, '0);
        step(1'b0, 1'b0, 1'b1, 3, rand_line());
        step(1'b0, 1'b0, 1'b1, 1, d1);
        step(1'b0, 1'b0, 1'b1, 1, rand_line());
        step(1'b0, 1'b0, 1'b0, 0, '0);
        step(1'b0, 1'b0, 1'b1, 0, d0);
        step(1'b0, 1'b0, 1'b1, 2, d2);
        idle(5, 1'b1);

        // Response racing its own allocation is dropped and flagged.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 0, rand_line());
        idle(2, 1'b1);

        // Alloc, fill and retire together at a steady count of two.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 0, '0);
        step(1'b1, 1'b0, 1'b0, 0, '0);
        step(1'b0, 1'b0, 1'b1, 0, rand_line());
        step(1'b1, 1'b1, 1'b1, 1, rand_line());
        idle(1, 1'b0);
        idle(3, 1'b1);

        // Reset with filled entries, then a late response to a pre-reset tag.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, i, rand_line());
        idle(1, 1'b0);
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1, rand_line());
        idle(2, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int cand[$];
            int r;
            int tag;
            if (i == 750) do_reset();
            foreach (live_q[j]) if (!filled_m[live_q[j]]) cand.push_back(live_q[j]);
            r = $urandom_range(0, 9);
            if (r < 7 && cand.size() > 0) tag = cand[$urandom_range(0, cand.size() - 1)];
            else if (r < 8)               tag = next_tag;
            else                          tag = $urandom_range(0, N - 1);
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 60, tag, rand_line());
        end

        check_eq("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
